// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and baud divider helper.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Clock cycles per bit; shared with the transmitter so both ends agree on timing.
    function automatic int unsigned baud_div(input int unsigned clk_freq,
                                             input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for bringing asynchronous levels into the clk domain.
module sync_2ff #(
    parameter int unsigned           WIDTH   = 1,
    parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First flop may go metastable; second flop gives it a full cycle to settle.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, valid/ready byte buffer, framing and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 10_000_000,
    parameter int unsigned BAUD_RATE = 115_200
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic                      frame_err,
    output logic                      overrun_err
);

    localparam int unsigned BAUD_DIV = baud_div(CLK_FREQ, BAUD_RATE);
    localparam int unsigned HALF_DIV = BAUD_DIV / 2;
    localparam int unsigned CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned IDX_W    = $clog2(UART_DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

    rx_state_t                 state;
    logic                      rx_s;
    logic                      rx_s_d;
    logic [CNT_W-1:0]          baud_cnt;
    logic [IDX_W-1:0]          bit_index;
    logic [UART_DATA_BITS-1:0] shift_reg;
    logic                      fall_edge;
    logic                      consume;

    // Line idles high, so the synchronizer resets to 1 to avoid a fake start edge.
    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // Previous synchronized level for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s_d <= 1'b1;
        end else begin
            rx_s_d <= rx_s;
        end
    end

    // Only a 1->0 transition starts a frame; a held-low line cannot retrigger.
    assign fall_edge = rx_s_d & ~rx_s;
    assign consume   = rx_valid & rx_ready;

    // Frame sequencer, bit timing, shift register and single-entry output buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RX_IDLE;
            baud_cnt    <= '0;
            bit_index   <= '0;
            shift_reg   <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;

            if (consume) begin
                rx_valid <= 1'b0;
            end

            case (state)
                RX_IDLE: begin
                    baud_cnt  <= '0;
                    bit_index <= '0;
                    if (fall_edge) begin
                        state <= RX_START;
                    end
                end

                RX_START: begin
                    if (baud_cnt == CNT_HALF) begin
                        baud_cnt <= '0;
                        // A line back high at mid start bit was a glitch.
                        state    <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

                RX_DATA: begin
                    if (baud_cnt == CNT_FULL) begin
                        baud_cnt  <= '0;
                        shift_reg <= {rx_s, shift_reg[UART_DATA_BITS-1:1]};
                        bit_index <= bit_index + IDX_W'(1);
                        if (bit_index == IDX_LAST) begin
                            state <= RX_STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

                RX_STOP: begin
                    if (baud_cnt == CNT_FULL) begin
                        baud_cnt <= '0;
                        state    <= RX_IDLE;
                        if (!rx_s) begin
                            frame_err <= 1'b1;
                        end else if (rx_valid && !rx_ready) begin
                            overrun_err <= 1'b1;
                        end else begin
                            // Load wins over a same-cycle consume, keeping rx_valid high.
                            rx_data  <= shift_reg;
                            rx_valid <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state    <= RX_IDLE;
                    baud_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus random frames against a timing-offset model.
module tb_uart_rx;

    localparam int BAUD = 86;
    localparam int HALF = 43;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun_err;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned cyc         = 0;
    bit          chk_en      = 0;

    // Reference model state: receiver expressed as sample offsets from the start edge.
    bit         m_busy  = 0;
    int         m_t     = 0;
    logic [7:0] m_byte  = '0;
    logic [7:0] m_data  = '0;
    bit         m_valid = 0;
    bit         m_ferr  = 0;
    bit         m_oerr  = 0;
    bit         d1 = 1, d2 = 1, d3 = 1;
    logic [7:0] m_out[$];

    // Observations of the DUT for literal checks.
    bit          prev_valid = 0;
    int unsigned rise_cyc   = 0;
    int unsigned valid_hi   = 0;
    int unsigned ferr_cnt   = 0;
    int unsigned oerr_cnt   = 0;
    int unsigned oerr_cyc   = 0;

    uart_rx #(
        .CLK_FREQ  (10_000_000),
        .BAUD_RATE (115_200)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .frame_err   (frame_err),
        .overrun_err (overrun_err)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic expect_byte(input string name, input logic [7:0] b);
        logic [8:0] got;
        got = 9'h100;
        if (m_out.size() > 0) got = {1'b0, m_out.pop_front()};
        check(name, 32'(got), 32'({1'b0, b}));
    endtask

    task automatic obs_clear();
        rise_cyc = 0;
        valid_hi = 0;
        ferr_cnt = 0;
        oerr_cnt = 0;
        oerr_cyc = 0;
    endtask

    // Drives the first nsym symbols of start, 8 data LSB first, stop; called on a negedge.
    task automatic send_frame(input logic [7:0] b, input bit stop, input int nsym);
        logic [9:0] sym;
        sym = {stop, b, 1'b0};
        for (int i = 0; i < nsym; i++) begin
            rx = sym[i];
            repeat (BAUD) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_cyc(input int unsigned c);
        while (cyc < c) @(negedge clk);
    endtask

    // Model: the receiver sees the pin two edges late; samples at HALF and HALF+n*BAUD.
    initial forever begin : model
        bit rs, rsd;
        int k;
        @(posedge clk);
        if (rst) begin
            m_busy  = 0;
            m_t     = 0;
            m_valid = 0;
            m_data  = '0;
            m_ferr  = 0;
            m_oerr  = 0;
            d1 = 1; d2 = 1; d3 = 1;
        end else begin
            rs  = d2;
            rsd = d3;
            m_ferr = 0;
            m_oerr = 0;
            if (m_valid && rx_ready) begin
                m_out.push_back(m_data);
                m_valid = 0;
            end
            if (!m_busy) begin
                if (rsd && !rs) begin
                    m_busy = 1;
                    m_t    = 0;
                end
            end else begin
                m_t++;
                if (m_t == HALF) begin
                    if (rs) m_busy = 0;
                end else if (m_t > HALF && ((m_t - HALF) % BAUD) == 0) begin
                    k = (m_t - HALF) / BAUD - 1;
                    if (k < 8) begin
                        m_byte[3'(k)] = rs;
                    end else begin
                        m_busy = 0;
                        if (!rs)          m_ferr = 1;
                        else if (m_valid) m_oerr = 1;
                        else begin
                            m_valid = 1;
                            m_data  = m_byte;
                        end
                    end
                end
            end
            d3 = d2;
            d2 = d1;
            d1 = rx;
        end
    end

    // Per-cycle comparison against the model, plus bookkeeping for literal checks.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("rx_valid",    32'(rx_valid),    32'(m_valid));
            check("rx_data",     32'(rx_data),     32'(m_data));
            check("frame_err",   32'(frame_err),   32'(m_ferr));
            check("overrun_err", 32'(overrun_err), 32'(m_oerr));
            if (rx_valid && !prev_valid) rise_cyc = cyc;
            if (rx_valid)    valid_hi++;
            if (frame_err)   ferr_cnt++;
            if (overrun_err) begin
                oerr_cnt++;
                oerr_cyc = cyc;
            end
            prev_valid = rx_valid;
        end
    end

    initial begin
        int unsigned t;
        bit          rand_done;
        rst = 1'b1;
        rx = 1'b1;
        rx_ready = 1'b0;
        rand_done = 0;
        repeat (3) @(negedge clk);
        chk_en = 1;
        check("reset rx_valid",    32'(rx_valid),    32'd0);
        check("reset rx_data",     32'(rx_data),     32'd0);
        check("reset frame_err",   32'(frame_err),   32'd0);
        check("reset overrun_err", 32'(overrun_err), 32'd0);
        rst = 1'b0;
        idle(20);

        // Single frame, consumer always ready.
        rx_ready = 1'b1;
        obs_clear();
        t = cyc;
        send_frame(8'hA5, 1'b1, 10);
        idle(100);
        check("a5 latency",     rise_cyc - t, 32'd820);
        check("a5 valid width", valid_hi, 32'd1);
        check("a5 frame_err",   ferr_cnt, 32'd0);
        expect_byte("a5 byte", 8'hA5);

        // Short low pulse is a false start, then a clean frame.
        obs_clear();
        rx = 1'b0;
        repeat (20) @(negedge clk);
        idle(300);
        check("glitch valid",     valid_hi, 32'd0);
        check("glitch frame_err", ferr_cnt, 32'd0);
        check("glitch no byte",   32'(m_out.size()), 32'd0);
        send_frame(8'h3C, 1'b1, 10);
        idle(100);
        expect_byte("after glitch byte", 8'h3C);

        // Bad stop bit followed by a long break.
        obs_clear();
        send_frame(8'h3C, 1'b0, 10);
        repeat (2000) @(negedge clk);
        check("break frame_err", ferr_cnt, 32'd1);
        check("break valid",     valid_hi, 32'd0);
        idle(200);
        check("break no retrigger", ferr_cnt, 32'd1);
        check("break no byte",      32'(m_out.size()), 32'd0);

        // Overrun: consumer stalled for two frames.
        rx_ready = 1'b0;
        obs_clear();
        send_frame(8'h11, 1'b1, 10);
        t = cyc;
        send_frame(8'h22, 1'b1, 10);
        idle(50);
        check("overrun count", oerr_cnt, 32'd1);
        check("overrun time",  oerr_cyc - t, 32'd820);
        check("held data",     32'(rx_data), 32'h11);
        check("held valid",    32'(rx_valid), 32'd1);
        rx_ready = 1'b1;
        idle(5);
        expect_byte("overrun kept byte", 8'h11);
        check("overrun dropped", 32'(m_out.size()), 32'd0);

        // Back-to-back frames with consume landing exactly on load cycles.
        rx_ready = 1'b0;
        obs_clear();
        t = cyc;
        fork
            begin
                send_frame(8'h00, 1'b1, 10);
                send_frame(8'hFF, 1'b1, 10);
                send_frame(8'h81, 1'b1, 10);
            end
            begin
                wait_cyc(t + 860 + 819);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
                wait_cyc(t + 1720 + 819);
                rx_ready = 1'b1;
            end
        join
        idle(50);
        check("b2b overrun",   oerr_cnt, 32'd0);
        check("b2b frame_err", ferr_cnt, 32'd0);
        expect_byte("b2b byte0", 8'h00);
        expect_byte("b2b byte1", 8'hFF);
        expect_byte("b2b byte2", 8'h81);
        check("b2b count", 32'(m_out.size()), 32'd0);

        // Reset mid-frame with a byte already buffered.
        rx_ready = 1'b0;
        send_frame(8'h99, 1'b1, 10);
        idle(20);
        send_frame(8'h77, 1'b1, 5);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midreset rx_valid",    32'(rx_valid),    32'd0);
        check("midreset rx_data",     32'(rx_data),     32'd0);
        check("midreset frame_err",   32'(frame_err),   32'd0);
        check("midreset overrun_err", 32'(overrun_err), 32'd0);
        rst = 1'b0;
        rx_ready = 1'b1;
        idle(50);
        check("midreset discarded", 32'(m_out.size()), 32'd0);
        send_frame(8'h5A, 1'b1, 10);
        idle(100);
        expect_byte("post reset byte", 8'h5A);

        // Random traffic: bytes, gaps, bad stops, glitches and a jittery consumer.
        fork
            begin
                for (int i = 0; i < 48; i++) begin
                    if ($urandom_range(0, 7) == 0) begin
                        rx = 1'b0;
                        repeat ($urandom_range(1, 40)) @(negedge clk);
                        idle(120);
                    end
                    send_frame(8'($urandom()), $urandom_range(0, 7) != 0, 10);
                    idle($urandom_range(0, 40));
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    rx_ready = $urandom_range(0, 3) != 0;
                    @(negedge clk);
                end
            end
        join
        rx_ready = 1'b1;
        idle(2000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
